// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encodings, frame constants, bit-period helper.
package uart_pkg;

  // One-hot-ish state encodings shared with the receive path
  localparam logic [3:0] IDLE   = 4'd0;
  localparam logic [3:0] START  = 4'd1;
  localparam logic [3:0] DATA   = 4'd2;
  localparam logic [3:0] PARITY = 4'd4;
  localparam logic [3:0] STOP   = 4'd8;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 11;

  // Clocks per serial bit; caller guarantees the result is >= 2
  function automatic int bit_cycles(input int clockrate, input int baudrate);
    return clockrate / baudrate;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Core-side write handshake for the UART transmitter.
interface uart_tx_if;
  import uart_pkg::*;

  logic                 send_flag;
  logic [DATA_BITS-1:0] send_data;
  logic                 send_ack;
  logic                 sendable;
  logic                 overflow;

  modport master (output send_flag, send_data, input send_ack, sendable, overflow);
  modport slave  (input send_flag, send_data, output send_ack, sendable, overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO; head is visible combinationally on rdata.
module uart_tx_fifo #(
  parameter int ADDR_L = 5,
  parameter int DATA_L = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_L-1:0] wdata,
  output logic [DATA_L-1:0] rdata,
  output logic [ADDR_L:0]   count,
  output logic              full,
  output logic              empty
);
  localparam int DEPTH = 1 << ADDR_L;

  logic [DATA_L-1:0] mem_q [DEPTH];
  logic [DATA_L-1:0] mem_d [DEPTH];
  logic [ADDR_L-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_L:0]   count_q, count_d;
  logic              push_ok, pop_ok;

  assign full    = (count_q == (ADDR_L+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem_q[rd_ptr_q];
  // Acceptance looks only at the pre-edge count: no full-FIFO bypass
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // Next-state for storage, pointers (wrap naturally) and occupancy
  always_comb begin
    mem_d = mem_q;
    if (push_ok) mem_d[wr_ptr_q] = wdata;
    wr_ptr_d = wr_ptr_q + ADDR_L'(push_ok);
    rd_ptr_d = rd_ptr_q + ADDR_L'(pop_ok);
    count_d  = count_q + (ADDR_L+1)'(push_ok) - (ADDR_L+1)'(pop_ok);
  end

  // Storage is not reset; only pointers and count matter
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/uart_tx.sv
// UART transmitter: byte FIFO feeding a start/8N-data/parity/stop serialiser.
module uart_tx
  import uart_pkg::*;
#(
  parameter int BAUDRATE  = 9600,
  parameter int CLOCKRATE = 100000000,
  parameter int ADDR_L    = 5
) (
  input  logic      CLK,
  input  logic      RST,
  uart_tx_if.slave  bus,
  output logic      busy,
  output logic      tx_done,
  output logic      Tx
);
  localparam int BC    = bit_cycles(CLOCKRATE, BAUDRATE);
  localparam int TW    = $clog2(BC);
  localparam int DEPTH = 1 << ADDR_L;
  localparam int CW    = ADDR_L + 1;

  logic [3:0]           state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 send_ack_q, send_ack_d;
  logic                 overflow_q, overflow_d;
  logic                 sendable_q, sendable_d;

  logic [DATA_BITS-1:0] rdata;
  logic [CW-1:0]        count, cnt_nxt;
  logic                 full, empty, pop, push_ok, wrap;

  uart_tx_fifo #(.ADDR_L(ADDR_L), .DATA_L(DATA_BITS)) u_fifo (
    .clk   (CLK),
    .rst_n (RST),
    .push  (bus.send_flag),
    .pop   (pop),
    .wdata (bus.send_data),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign wrap         = (timer_q == TW'(BC - 1));
  assign push_ok      = bus.send_flag && !full;
  assign cnt_nxt      = count + CW'(push_ok) - CW'(pop);
  assign busy         = (state_q != IDLE);
  assign tx_done      = (state_q == STOP) && wrap;
  assign Tx           = tx_q;
  assign bus.send_ack = send_ack_q;
  assign bus.overflow = overflow_q;
  assign bus.sendable = sendable_q;

  // Frame sequencing, bit timing and handshake outputs
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    idx_d      = idx_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    tx_d       = tx_q;
    pop        = 1'b0;
    // Timer only runs inside a frame; wrap returns it to 0 for the next bit
    if (state_q != IDLE) timer_d = wrap ? '0 : timer_q + TW'(1);
    case (state_q)
      IDLE: if (!empty) begin
        pop = 1'b1; shreg_d = rdata; par_d = ^rdata;
        tx_d = 1'b0; state_d = START; timer_d = '0;
      end
      START: if (wrap) begin
        state_d = DATA; idx_d = '0; tx_d = shreg_q[0];
      end
      DATA: if (wrap) begin
        if (idx_q == 3'(DATA_BITS - 1)) begin
          state_d = PARITY; tx_d = par_q;
        end else begin
          idx_d = idx_q + 3'd1; tx_d = shreg_q[idx_q + 3'd1];
        end
      end
      PARITY: if (wrap) begin
        state_d = STOP; tx_d = 1'b1;
      end
      STOP: if (wrap) begin
        // Chain straight into the next frame when more bytes are queued
        if (!empty) begin
          pop = 1'b1; shreg_d = rdata; par_d = ^rdata;
          tx_d = 1'b0; state_d = START;
        end else begin
          state_d = IDLE; tx_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE; tx_d = 1'b1; timer_d = '0;
      end
    endcase
    send_ack_d = push_ok;
    overflow_d = bus.send_flag && full;
    sendable_d = (cnt_nxt < CW'(DEPTH));
  end

  // Registered state with synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      idx_q      <= '0;
      shreg_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      send_ack_q <= 1'b0;
      overflow_q <= 1'b0;
      sendable_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      idx_q      <= idx_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      send_ack_q <= send_ack_d;
      overflow_q <= overflow_d;
      sendable_q <= sendable_d;
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx with 8 clocks per bit and a 4-deep FIFO.
module tb_uart_tx;
  logic clk, rst;
  logic busy, tx_done, Tx;
  int   total, bad;

  uart_tx_if bus();

  uart_tx #(.BAUDRATE(10), .CLOCKRATE(80), .ADDR_L(2)) dut (
    .CLK     (clk),
    .RST     (rst),
    .bus     (bus),
    .busy    (busy),
    .tx_done (tx_done),
    .Tx      (Tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; bus.send_flag = 1'b0; bus.send_data = 8'h00;
    repeat (3) tick();
    total++; if (Tx !== 1'b1) begin bad++; $display("FAIL reset_tx got %b want 1", Tx); end
    total++; if (bus.sendable !== 1'b1) begin bad++; $display("FAIL reset_sendable got %b want 1", bus.sendable); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", busy); end
    total++; if (bus.send_ack !== 1'b0) begin bad++; $display("FAIL reset_ack got %b want 0", bus.send_ack); end
    total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got %b want 0", bus.overflow); end
    total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_done got %b want 0", tx_done); end
    rst = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      total++;
      if (Tx !== 1'b1 || busy !== 1'b0) begin
        bad++; $display("FAIL idle_quiet cycle %0d got tx=%b busy=%b want tx=1 busy=0", k, Tx, busy);
      end
    end
  endtask

  // f[i] is the line level of bit slot i: start, d0..d7, parity, stop
  task automatic test_frame(input logic [7:0] b, input logic [10:0] f, input string name);
    bus.send_flag = 1'b1; bus.send_data = b;
    tick();
    total++; if (bus.send_ack !== 1'b1) begin bad++; $display("FAIL %s_ack got %b want 1", name, bus.send_ack); end
    bus.send_flag = 1'b0;
    tick();
    total++; if (bus.send_ack !== 1'b0) begin bad++; $display("FAIL %s_ack_pulse got %b want 0", name, bus.send_ack); end
    for (int k = 0; k < 88; k++) begin
      total++;
      if (Tx !== f[k/8]) begin bad++; $display("FAIL %s_line cycle %0d got %b want %b", name, k + 1, Tx, f[k/8]); end
      total++;
      if (tx_done !== (k == 87)) begin bad++; $display("FAIL %s_done cycle %0d got %b want %b", name, k + 1, tx_done, (k == 87)); end
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy cycle %0d got %b want 1", name, k + 1, busy); end
      tick();
    end
    total++; if (busy !== 1'b0 || Tx !== 1'b1) begin bad++; $display("FAIL %s_end got busy=%b tx=%b want busy=0 tx=1", name, busy, Tx); end
  endtask

  task automatic test_back_to_back;
    logic [10:0] fr [5];
    logic [7:0]  wr [5];
    fr[0] = {1'b1, 1'b1, 8'h07, 1'b0};
    fr[1] = {1'b1, 1'b0, 8'hA5, 1'b0};
    fr[2] = {1'b1, 1'b0, 8'h3C, 1'b0};
    fr[3] = {1'b1, 1'b0, 8'hFF, 1'b0};
    fr[4] = {1'b1, 1'b0, 8'h00, 1'b0};
    wr[0] = 8'hA5; wr[1] = 8'h3C; wr[2] = 8'hFF; wr[3] = 8'h00; wr[4] = 8'h77;
    bus.send_flag = 1'b1; bus.send_data = 8'h07;
    tick();
    bus.send_flag = 1'b0;
    tick();
    for (int k = 0; k < 440; k++) begin
      total++;
      if (Tx !== fr[k/88][(k%88)/8]) begin
        bad++; $display("FAIL b2b_line cycle %0d got %b want %b", k + 1, Tx, fr[k/88][(k%88)/8]);
      end
      if (k >= 11 && k <= 14) begin
        total++; if (bus.send_ack !== 1'b1) begin bad++; $display("FAIL b2b_ack write %0d got %b want 1", k - 10, bus.send_ack); end
      end
      if (k >= 11 && k <= 13) begin
        total++; if (bus.sendable !== 1'b1) begin bad++; $display("FAIL b2b_sendable_hi cycle %0d got %b want 1", k + 1, bus.sendable); end
      end
      if (k == 14) begin
        total++; if (bus.sendable !== 1'b0) begin bad++; $display("FAIL b2b_sendable_full got %b want 0", bus.sendable); end
      end
      if (k == 15) begin
        total++; if (bus.send_ack !== 1'b0 || bus.overflow !== 1'b1) begin
          bad++; $display("FAIL b2b_overflow got ack=%b ovf=%b want ack=0 ovf=1", bus.send_ack, bus.overflow);
        end
      end
      if (k == 16) begin
        total++; if (bus.overflow !== 1'b0) begin bad++; $display("FAIL b2b_ovf_pulse got %b want 0", bus.overflow); end
      end
      if (k == 88) begin
        total++; if (bus.sendable !== 1'b1) begin bad++; $display("FAIL b2b_sendable_pop got %b want 1", bus.sendable); end
      end
      bus.send_flag = (k >= 10 && k <= 14);
      if (k >= 10 && k <= 14) bus.send_data = wr[k-10];
      tick();
    end
    total++; if (busy !== 1'b0 || Tx !== 1'b1) begin bad++; $display("FAIL b2b_end got busy=%b tx=%b want busy=0 tx=1", busy, Tx); end
  endtask

  task automatic test_write_at_stop_end;
    bus.send_flag = 1'b1; bus.send_data = 8'h3C;
    tick();
    bus.send_flag = 1'b0;
    tick();
    repeat (87) tick();
    total++; if (tx_done !== 1'b1 || Tx !== 1'b1) begin bad++; $display("FAIL edge_last_stop got done=%b tx=%b want done=1 tx=1", tx_done, Tx); end
    bus.send_flag = 1'b1; bus.send_data = 8'hC3;
    tick();
    bus.send_flag = 1'b0;
    total++; if (busy !== 1'b0 || Tx !== 1'b1 || bus.send_ack !== 1'b1) begin
      bad++; $display("FAIL edge_idle got busy=%b tx=%b ack=%b want busy=0 tx=1 ack=1", busy, Tx, bus.send_ack);
    end
    tick();
    total++; if (Tx !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL edge_restart got tx=%b busy=%b want tx=0 busy=1", Tx, busy); end
    repeat (90) tick();
    total++; if (busy !== 1'b0 || Tx !== 1'b1) begin bad++; $display("FAIL edge_drain got busy=%b tx=%b want busy=0 tx=1", busy, Tx); end
  endtask

  task automatic test_reset_mid_frame;
    bus.send_flag = 1'b1; bus.send_data = 8'h55;
    tick();
    bus.send_data = 8'h11;
    tick();
    bus.send_data = 8'h22;
    tick();
    bus.send_flag = 1'b0;
    repeat (38) tick();
    // cycle 40 of the frame sits in data bit 3 of 0x55
    total++; if (Tx !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL mid_before got tx=%b busy=%b want tx=0 busy=1", Tx, busy); end
    rst = 1'b0;
    tick();
    total++; if (Tx !== 1'b1 || busy !== 1'b0 || bus.sendable !== 1'b1 || bus.send_ack !== 1'b0) begin
      bad++; $display("FAIL mid_reset got tx=%b busy=%b sendable=%b ack=%b want 1 0 1 0", Tx, busy, bus.sendable, bus.send_ack);
    end
    rst = 1'b1;
    for (int k = 0; k < 150; k++) begin
      tick();
      total++;
      if (Tx !== 1'b1 || busy !== 1'b0) begin
        bad++; $display("FAIL mid_discard cycle %0d got tx=%b busy=%b want tx=1 busy=0", k, Tx, busy);
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    test_reset();
    test_frame(8'h55, {1'b1, 1'b0, 8'h55, 1'b0}, "byte55");
    test_frame(8'h01, {1'b1, 1'b1, 8'h01, 1'b0}, "byte01");
    test_back_to_back();
    test_write_at_stop_end();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
